coreahblite_mstage_dphase: RTL and testbench
============================================

// Module: coreahblite_mstage_dphase
// PURPOSE
//  Master-side data-phase stage of the AHB-Lite matrix; consumes the address decoder's one-hot slot decode.
//  Qualifies the decode with HTRANS/HREADY to drive per-slot HSEL, and registers the accepted selection for the data phase.
//  Muxes HREADYOUT/HRESP/HRDATA from the selected slot back to the master.
//  Contains the default slave: two-cycle ERROR response for reserved or disabled addresses, OKAY for IDLE/BUSY transfers.
// PARAMETERS
//  M_AHBSLOTENABLE  17'h1FFFF  bit n=1: slot n reachable from this master; bit 16 = huge/combined slot
//  ERR_ON_DISABLED  1          1: decode hit on a disabled slot returns ERROR; 0: returns OKAY, zero data
// PORTS
//  HCLK          in   1      clock; all state on rising edge
//  HRESET        in   1      reset, synchronous, active-high
//  HTRANS        in   2      master transfer type (IDLE 00, BUSY 01, NONSEQ 10, SEQ 11)
//  ADDRDEC       in   17     one-hot slot decode of current master address (bit 16 = huge slot)
//  RESERVEDDEC   in   1      current address falls in the reserved region
//  HSEL_S        out  17     per-slot address-phase select
//  HREADY_S      out  1      HREADY broadcast to all slots (equals HREADY_M)
//  HREADYOUT_S   in   17     per-slot HREADYOUT
//  HRESP_S       in   17     per-slot HRESP (1 = ERROR)
//  HRDATA_S      in   17*32  per-slot read data; slot n at [32n+31:32n]
//  HREADY_M      out  1      HREADY to master
//  HRESP_M       out  1      HRESP to master
//  HRDATA_M      out  32     read data to master
// BEHAVIOUR
//  Reset (HRESET=1 at edge): dsel=0, err state IDLE; HREADY_M=1, HRESP_M=0, HRDATA_M=0; HSEL_S forced to 0 while HRESET=1.
//  Valid address phase: addr_ok = HTRANS[1] & HREADY_M & ~HRESET.
//  Hit vector: hit = ADDRDEC & M_AHBSLOTENABLE.
//    HSEL_S = addr_ok ? hit : 0 (combinational, zero latency).
//  Illegal access: bad = addr_ok & (RESERVEDDEC | (ADDRDEC!=0 & hit==0 & ERR_ON_DISABLED) | ADDRDEC==0 & ERR_ON_DISABLED).
//  dsel register: on each edge where HREADY_M=1, dsel <= addr_ok ? hit : 0; held while HREADY_M=0.
//  Data-phase outputs when dsel != 0 (one-hot; only the selected slot n is used):
//    HREADY_M = HREADYOUT_S[n]; HRESP_M = HRESP_S[n]; HRDATA_M = HRDATA_S[n].
//  Data-phase outputs when dsel == 0: driven by the default-slave FSM. HRDATA_M = 0.
//  Default-slave FSM, states IDLE, ERR1, ERR2:
//    IDLE: HREADY_M=1, HRESP_M=0. Goes to ERR1 on an edge where bad=1; otherwise stays in IDLE.
//    ERR1: HREADY_M=0, HRESP_M=1. Unconditionally goes to ERR2.
//    ERR2: HREADY_M=1, HRESP_M=1. Goes to ERR1 if bad=1 again at this edge, otherwise to IDLE.
//  Slave ERROR passes through unmodified; the slave owns its own two-cycle sequencing.
//  Address phase during ERR1 is not accepted (HREADY_M=0), so HSEL_S=0.
//    A NONSEQ presented in ERR2 is accepted normally.
//  Wait states: a slot holding HREADYOUT low freezes dsel and HSEL_S (HSEL_S is gated off via HREADY_M).
//  Back-to-back: a NONSEQ accepted in the final data cycle of the previous transfer gives zero dead cycles.
//  Reset mid-transfer: dsel and FSM clear at that edge.
//    The next cycle shows HREADY_M=1, HRESP_M=0 regardless of slot state.
//  One-hot violation on ADDRDEC (more than one bit set): not legal input; assertion only, no recovery logic.
// STRUCTURE
//  Shared package coreahblite_pkg:
//    NUM_SLOTS=17; HTRANS_IDLE/BUSY/NONSEQ/SEQ constants; dflt_state_t enum {IDLE, ERR1, ERR2}.
//  One sub-module: coreahblite_dflt_slave, containing the FSM only.
//    Ports: HCLK, HRESET, HREADY_M, bad -> dflt_hready, dflt_hresp.
//  The top level holds dsel, the HSEL gating, and the one-hot AND-OR data mux (no priority encoder).
// TESTING
//  1. Reset: hold HRESET=1 for 3 cycles with HTRANS=NONSEQ and ADDRDEC=17'h00004.
//     -> HSEL_S=0, HREADY_M=1, HRESP_M=0, HRDATA_M=0 throughout.
//  2. Single read from slot 2 with 2 wait states: ADDRDEC=17'h00004, NONSEQ, HRDATA_S slot2=32'hCAFE_0002.
//     -> HSEL_S=17'h00004 for 1 cycle; HREADY_M low for 2 cycles; HRDATA_M=32'hCAFE_0002 on the ready cycle.
//  3. Reserved access: RESERVEDDEC=1, ADDRDEC=0, NONSEQ.
//     -> next cycle HREADY_M=0/HRESP_M=1, following cycle 1/1, then 1/0; HSEL_S=0 throughout.
//  4. Disabled slot: M_AHBSLOTENABLE=17'h1FFF7, NONSEQ to slot 3.
//     -> HSEL_S=0, ERROR pair as in test 3.
//     With ERR_ON_DISABLED=0 -> HREADY_M=1, HRESP_M=0, HRDATA_M=0.
//  5. Back-to-back: NONSEQ slot 1, then SEQ slot 16 (huge slot) on consecutive cycles, no waits.
//     -> dsel 17'h00002 then 17'h10000; HRDATA_M follows slot 1 then slot 16 with no gap.
//  6. Reset asserted during a slot-5 wait state (HREADYOUT_S[5]=0).
//     -> next cycle dsel=0, HREADY_M=1, HRESP_M=0.

Source files
------------

// File: rtl/coreahblite_pkg.sv
// Shared types and constants for the AHB-Lite matrix master-side stages.
//   NUM_SLOTS    : slots per master (16 regular + 1 huge/combined slot)
//   DATA_W       : read-data width
//   HTRANS_*     : AHB transfer-type encodings
//   dflt_state_t : default-slave response states
package coreahblite_pkg;

    localparam int unsigned NUM_SLOTS = 17;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned HTRANS_W  = 2;

    localparam logic [HTRANS_W-1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [HTRANS_W-1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [HTRANS_W-1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [HTRANS_W-1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ERR1 = 2'd1,
        ERR2 = 2'd2
    } dflt_state_t;

endpackage

// File: rtl/coreahblite_mstage_dphase_if.sv
// Bus bundle between one AHB-Lite master, its address decoder and the slots.
//   master modport : view of the upstream master/decoder and slot models
//   slave modport  : view of the data-phase stage itself
interface coreahblite_mstage_dphase_if;
    import coreahblite_pkg::*;

    logic [HTRANS_W-1:0]         HTRANS;
    logic [NUM_SLOTS-1:0]        ADDRDEC;
    logic                        RESERVEDDEC;
    logic [NUM_SLOTS-1:0]        HSEL_S;
    logic                        HREADY_S;
    logic [NUM_SLOTS-1:0]        HREADYOUT_S;
    logic [NUM_SLOTS-1:0]        HRESP_S;
    logic [NUM_SLOTS*DATA_W-1:0] HRDATA_S;
    logic                        HREADY_M;
    logic                        HRESP_M;
    logic [DATA_W-1:0]           HRDATA_M;

    modport master (
        output HTRANS, ADDRDEC, RESERVEDDEC, HREADYOUT_S, HRESP_S, HRDATA_S,
        input  HSEL_S, HREADY_S, HREADY_M, HRESP_M, HRDATA_M
    );

    modport slave (
        input  HTRANS, ADDRDEC, RESERVEDDEC, HREADYOUT_S, HRESP_S, HRDATA_S,
        output HSEL_S, HREADY_S, HREADY_M, HRESP_M, HRDATA_M
    );

endinterface

// File: rtl/coreahblite_dflt_slave.sv
// Default slave: two-cycle ERROR response for illegal accesses, OKAY otherwise.
//   HCLK, HRESET : clock, synchronous active-high reset
//   HREADY_M     : master-side HREADY (transfer accepted when high)
//   bad          : illegal access presented in a valid address phase
//   dflt_hready  : default-slave HREADY (registered)
//   dflt_hresp   : default-slave HRESP, 1 = ERROR (registered)
module coreahblite_dflt_slave
    import coreahblite_pkg::*;
(
    input  logic HCLK,
    input  logic HRESET,
    input  logic HREADY_M,
    input  logic bad,
    output logic dflt_hready,
    output logic dflt_hresp
);

    dflt_state_t state, state_nxt;
    logic        hready_nxt, hresp_nxt;
    logic        take_err;

    assign take_err = bad & HREADY_M;

    // Next state and the response that state will present.
    always_comb begin
        state_nxt  = state;
        hready_nxt = 1'b1;
        hresp_nxt  = 1'b0;
        case (state)
            IDLE:    state_nxt = take_err ? ERR1 : IDLE;
            ERR1:    state_nxt = ERR2;
            ERR2:    state_nxt = take_err ? ERR1 : IDLE;
            default: state_nxt = IDLE;
        endcase
        case (state_nxt)
            ERR1: begin
                hready_nxt = 1'b0;
                hresp_nxt  = 1'b1;
            end
            ERR2: begin
                hready_nxt = 1'b1;
                hresp_nxt  = 1'b1;
            end
            default: begin
                hready_nxt = 1'b1;
                hresp_nxt  = 1'b0;
            end
        endcase
    end

    // State and response registers.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state       <= IDLE;
            dflt_hready <= 1'b1;
            dflt_hresp  <= 1'b0;
        end else begin
            state       <= state_nxt;
            dflt_hready <= hready_nxt;
            dflt_hresp  <= hresp_nxt;
        end
    end

endmodule

// File: rtl/coreahblite_mstage_dphase.sv
// Master-side data-phase stage: qualifies the slot decode into per-slot HSEL,
// tracks the selected slot for the data phase and returns its response.
//   HCLK, HRESET : clock, synchronous active-high reset
//   bus          : slave modport of coreahblite_mstage_dphase_if
//                  (HTRANS/ADDRDEC/RESERVEDDEC/slot responses in,
//                   HSEL_S/HREADY_S/HREADY_M/HRESP_M/HRDATA_M out)
module coreahblite_mstage_dphase
    import coreahblite_pkg::*;
#(
    parameter logic [NUM_SLOTS-1:0] M_AHBSLOTENABLE = 17'h1FFFF,
    parameter bit                   ERR_ON_DISABLED = 1'b1
)(
    input  logic                           HCLK,
    input  logic                           HRESET,
    coreahblite_mstage_dphase_if.slave     bus
);

    logic [NUM_SLOTS-1:0] hit;
    logic [NUM_SLOTS-1:0] dsel;
    logic                 addr_ok;
    logic                 bad;
    logic                 hready_m;
    logic                 dflt_hready, dflt_hresp;
    logic                 sel_hready, sel_hresp;
    logic [DATA_W-1:0]    sel_rdata;

    assign addr_ok = bus.HTRANS[1] & hready_m & ~HRESET;
    assign hit     = bus.ADDRDEC & M_AHBSLOTENABLE;

    // A zero hit covers both "no decode" and "decode on a disabled slot".
    assign bad = addr_ok & (bus.RESERVEDDEC | (ERR_ON_DISABLED & (hit == '0)));

    assign bus.HSEL_S = addr_ok ? hit : '0;

    // Data-phase selection, frozen while the current transfer is stalled.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dsel <= '0;
        end else if (hready_m) begin
            dsel <= addr_ok ? hit : '0;
        end
    end

    // One-hot AND-OR return mux; yields zeros when no slot is selected.
    always_comb begin
        sel_rdata = '0;
        for (int n = 0; n < int'(NUM_SLOTS); n++) begin
            sel_rdata = sel_rdata | (bus.HRDATA_S[n*DATA_W +: DATA_W] & {DATA_W{dsel[n]}});
        end
        sel_hready = |(dsel & bus.HREADYOUT_S);
        sel_hresp  = |(dsel & bus.HRESP_S);
    end

    assign hready_m     = (dsel != '0) ? sel_hready : dflt_hready;
    assign bus.HREADY_M = hready_m;
    assign bus.HREADY_S = hready_m;
    assign bus.HRESP_M  = (dsel != '0) ? sel_hresp : dflt_hresp;
    assign bus.HRDATA_M = sel_rdata;

    coreahblite_dflt_slave u_dflt (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .HREADY_M    (hready_m),
        .bad         (bad),
        .dflt_hready (dflt_hready),
        .dflt_hresp  (dflt_hresp)
    );

    // The decoder must never flag more than one slot for a real transfer.
    always_ff @(posedge HCLK) begin
        if (!HRESET && bus.HTRANS[1]) begin
            assert ($onehot0(bus.ADDRDEC));
        end
    end

endmodule

// File: tb/tb_coreahblite_mstage_dphase.sv
// Directed self-checking bench for coreahblite_mstage_dphase.
// u0: all slots enabled; u1: slot 3 disabled, ERROR; u2: slot 3 disabled, OKAY.
module tb_coreahblite_mstage_dphase;
    import coreahblite_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [HTRANS_W-1:0]         htrans   = HTRANS_IDLE;
    logic [NUM_SLOTS-1:0]        addrdec  = '0;
    logic                        reserved = 1'b0;
    logic [NUM_SLOTS-1:0]        hreadyout = '1;
    logic [NUM_SLOTS-1:0]        hresp     = '0;
    logic [NUM_SLOTS*DATA_W-1:0] hrdata    = '0;

    int pass_cnt = 0;
    int total    = 0;

    coreahblite_mstage_dphase_if i0 ();
    coreahblite_mstage_dphase_if i1 ();
    coreahblite_mstage_dphase_if i2 ();

    assign i0.HTRANS = htrans;   assign i1.HTRANS = htrans;   assign i2.HTRANS = htrans;
    assign i0.ADDRDEC = addrdec; assign i1.ADDRDEC = addrdec; assign i2.ADDRDEC = addrdec;
    assign i0.RESERVEDDEC = reserved; assign i1.RESERVEDDEC = reserved; assign i2.RESERVEDDEC = reserved;
    assign i0.HREADYOUT_S = hreadyout; assign i1.HREADYOUT_S = hreadyout; assign i2.HREADYOUT_S = hreadyout;
    assign i0.HRESP_S = hresp;   assign i1.HRESP_S = hresp;   assign i2.HRESP_S = hresp;
    assign i0.HRDATA_S = hrdata; assign i1.HRDATA_S = hrdata; assign i2.HRDATA_S = hrdata;

    coreahblite_mstage_dphase u0 (.HCLK(clk), .HRESET(rst), .bus(i0));
    coreahblite_mstage_dphase #(.M_AHBSLOTENABLE(17'h1FFF7), .ERR_ON_DISABLED(1'b1))
        u1 (.HCLK(clk), .HRESET(rst), .bus(i1));
    coreahblite_mstage_dphase #(.M_AHBSLOTENABLE(17'h1FFF7), .ERR_ON_DISABLED(1'b0))
        u2 (.HCLK(clk), .HRESET(rst), .bus(i2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        htrans   = HTRANS_IDLE;
        addrdec  = '0;
        reserved = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        htrans  = HTRANS_NONSEQ;
        addrdec = 17'h00004;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++; if (i0.HSEL_S !== 17'h0) $display("FAIL reset_hsel c%0d got %h exp 0", c, i0.HSEL_S); else pass_cnt++;
            total++; if (i0.HREADY_M !== 1'b1) $display("FAIL reset_hready c%0d got %b exp 1", c, i0.HREADY_M); else pass_cnt++;
            total++; if (i0.HRESP_M !== 1'b0) $display("FAIL reset_hresp c%0d got %b exp 0", c, i0.HRESP_M); else pass_cnt++;
            total++; if (i0.HRDATA_M !== 32'h0) $display("FAIL reset_hrdata c%0d got %h exp 0", c, i0.HRDATA_M); else pass_cnt++;
        end
        rst = 1'b0;
    endtask

    task automatic test_wait_read();
        hrdata[2*DATA_W +: DATA_W] = 32'hCAFE_0002;
        hreadyout[2] = 1'b0;
        htrans  = HTRANS_NONSEQ;
        addrdec = 17'h00004;
        #1;
        total++; if (i0.HSEL_S !== 17'h00004) $display("FAIL wr_hsel got %h exp 00004", i0.HSEL_S); else pass_cnt++;
        tick();
        htrans = HTRANS_IDLE; addrdec = '0;
        #1;
        total++; if (i0.HREADY_M !== 1'b0) $display("FAIL wr_wait1 got %b exp 0", i0.HREADY_M); else pass_cnt++;
        total++; if (i0.HREADY_S !== 1'b0) $display("FAIL wr_hready_s got %b exp 0", i0.HREADY_S); else pass_cnt++;
        // New NONSEQ during a wait state must not reach the slots.
        htrans = HTRANS_NONSEQ; addrdec = 17'h00008;
        #1;
        total++; if (i0.HSEL_S !== 17'h0) $display("FAIL wr_hsel_gated got %h exp 0", i0.HSEL_S); else pass_cnt++;
        htrans = HTRANS_IDLE; addrdec = '0;
        tick();
        total++; if (i0.HREADY_M !== 1'b0) $display("FAIL wr_wait2 got %b exp 0", i0.HREADY_M); else pass_cnt++;
        hreadyout[2] = 1'b1;
        #1;
        total++; if (i0.HREADY_M !== 1'b1) $display("FAIL wr_ready got %b exp 1", i0.HREADY_M); else pass_cnt++;
        total++; if (i0.HRDATA_M !== 32'hCAFE_0002) $display("FAIL wr_data got %h exp cafe0002", i0.HRDATA_M); else pass_cnt++;
        tick();
        total++; if (i0.HRDATA_M !== 32'h0) $display("FAIL wr_data_after got %h exp 0", i0.HRDATA_M); else pass_cnt++;
    endtask

    task automatic test_reserved();
        go_idle();
        hrdata[1*DATA_W +: DATA_W] = 32'h1111_0001;
        reserved = 1'b1; addrdec = '0; htrans = HTRANS_NONSEQ;
        #1;
        total++; if (i0.HSEL_S !== 17'h0) $display("FAIL rsv_hsel0 got %h exp 0", i0.HSEL_S); else pass_cnt++;
        tick();
        reserved = 1'b0; htrans = HTRANS_IDLE;
        #1;
        total++; if ({i0.HREADY_M, i0.HRESP_M} !== 2'b01) $display("FAIL rsv_err1 got %b exp 01", {i0.HREADY_M, i0.HRESP_M}); else pass_cnt++;
        // Address phase offered in ERR1 is not accepted.
        htrans = HTRANS_NONSEQ; addrdec = 17'h00002;
        #1;
        total++; if (i0.HSEL_S !== 17'h0) $display("FAIL rsv_hsel_err1 got %h exp 0", i0.HSEL_S); else pass_cnt++;
        htrans = HTRANS_IDLE; addrdec = '0;
        tick();
        total++; if ({i0.HREADY_M, i0.HRESP_M} !== 2'b11) $display("FAIL rsv_err2 got %b exp 11", {i0.HREADY_M, i0.HRESP_M}); else pass_cnt++;
        // NONSEQ in ERR2 is accepted normally.
        htrans = HTRANS_NONSEQ; addrdec = 17'h00002;
        #1;
        total++; if (i0.HSEL_S !== 17'h00002) $display("FAIL rsv_hsel_err2 got %h exp 00002", i0.HSEL_S); else pass_cnt++;
        tick();
        htrans = HTRANS_IDLE; addrdec = '0;
        #1;
        total++; if ({i0.HREADY_M, i0.HRESP_M} !== 2'b10) $display("FAIL rsv_okay got %b exp 10", {i0.HREADY_M, i0.HRESP_M}); else pass_cnt++;
        total++; if (i0.HRDATA_M !== 32'h1111_0001) $display("FAIL rsv_slot1_data got %h exp 11110001", i0.HRDATA_M); else pass_cnt++;
    endtask

    task automatic test_disabled();
        go_idle();
        htrans = HTRANS_NONSEQ; addrdec = 17'h00008;
        #1;
        total++; if (i1.HSEL_S !== 17'h0) $display("FAIL dis_hsel_err got %h exp 0", i1.HSEL_S); else pass_cnt++;
        total++; if (i2.HSEL_S !== 17'h0) $display("FAIL dis_hsel_ok got %h exp 0", i2.HSEL_S); else pass_cnt++;
        total++; if (i0.HSEL_S !== 17'h00008) $display("FAIL dis_hsel_enabled got %h exp 00008", i0.HSEL_S); else pass_cnt++;
        tick();
        htrans = HTRANS_IDLE; addrdec = '0;
        #1;
        total++; if ({i1.HREADY_M, i1.HRESP_M} !== 2'b01) $display("FAIL dis_err1 got %b exp 01", {i1.HREADY_M, i1.HRESP_M}); else pass_cnt++;
        total++; if ({i2.HREADY_M, i2.HRESP_M} !== 2'b10) $display("FAIL dis_okay got %b exp 10", {i2.HREADY_M, i2.HRESP_M}); else pass_cnt++;
        total++; if (i2.HRDATA_M !== 32'h0) $display("FAIL dis_okay_data got %h exp 0", i2.HRDATA_M); else pass_cnt++;
        tick();
        total++; if ({i1.HREADY_M, i1.HRESP_M} !== 2'b11) $display("FAIL dis_err2 got %b exp 11", {i1.HREADY_M, i1.HRESP_M}); else pass_cnt++;
        tick();
        total++; if ({i1.HREADY_M, i1.HRESP_M} !== 2'b10) $display("FAIL dis_idle got %b exp 10", {i1.HREADY_M, i1.HRESP_M}); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        go_idle();
        hrdata[16*DATA_W +: DATA_W] = 32'hAAAA_0010;
        htrans = HTRANS_NONSEQ; addrdec = 17'h00002;
        #1;
        total++; if (i0.HSEL_S !== 17'h00002) $display("FAIL b2b_hsel1 got %h exp 00002", i0.HSEL_S); else pass_cnt++;
        tick();
        htrans = HTRANS_SEQ; addrdec = 17'h10000;
        #1;
        total++; if (u0.dsel !== 17'h00002) $display("FAIL b2b_dsel1 got %h exp 00002", u0.dsel); else pass_cnt++;
        total++; if (i0.HSEL_S !== 17'h10000) $display("FAIL b2b_hsel16 got %h exp 10000", i0.HSEL_S); else pass_cnt++;
        total++; if (i0.HRDATA_M !== 32'h1111_0001) $display("FAIL b2b_data1 got %h exp 11110001", i0.HRDATA_M); else pass_cnt++;
        tick();
        htrans = HTRANS_IDLE; addrdec = '0;
        #1;
        total++; if (u0.dsel !== 17'h10000) $display("FAIL b2b_dsel16 got %h exp 10000", u0.dsel); else pass_cnt++;
        total++; if (i0.HRDATA_M !== 32'hAAAA_0010) $display("FAIL b2b_data16 got %h exp aaaa0010", i0.HRDATA_M); else pass_cnt++;
        total++; if (i0.HREADY_M !== 1'b1) $display("FAIL b2b_hready got %b exp 1", i0.HREADY_M); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        go_idle();
        hreadyout[5] = 1'b0;
        htrans = HTRANS_NONSEQ; addrdec = 17'h00020;
        tick();
        // Keep requesting slot 1 across the stall; it must not be taken.
        addrdec = 17'h00002;
        #1;
        total++; if (i0.HSEL_S !== 17'h0) $display("FAIL rm_hsel_gated got %h exp 0", i0.HSEL_S); else pass_cnt++;
        tick();
        total++; if (u0.dsel !== 17'h00020) $display("FAIL rm_dsel_held got %h exp 00020", u0.dsel); else pass_cnt++;
        total++; if (i0.HREADY_M !== 1'b0) $display("FAIL rm_wait got %b exp 0", i0.HREADY_M); else pass_cnt++;
        rst = 1'b1; htrans = HTRANS_IDLE; addrdec = '0;
        tick();
        rst = 1'b0;
        hresp[5] = 1'b1;
        #1;
        total++; if (u0.dsel !== 17'h0) $display("FAIL rm_dsel got %h exp 0", u0.dsel); else pass_cnt++;
        total++; if ({i0.HREADY_M, i0.HRESP_M} !== 2'b10) $display("FAIL rm_resp got %b exp 10", {i0.HREADY_M, i0.HRESP_M}); else pass_cnt++;
        hreadyout[5] = 1'b1;
        hresp[5] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_wait_read();
        test_reserved();
        test_disabled();
        test_back_to_back();
        test_reset_mid();
        tick();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
